// File: rtl/sao_deci_type_sched.sv
// sao_deci_type_sched: walks NUM_TYPE SAO offset types per CTU, streams NUM_CATEGORY
// distortions per type into the one-type accumulator, keeps the minimum per-type sum
// and hands the winning type and its distortion to the SAO parameter writer.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   start, abort         begin a CTU decision (IDLE only) / cancel from any state
//   busy, type_idx       not IDLE / type currently being accumulated
//   dist_in, dist_valid, dist_ready   per-category distortion stream
//   accu_en, accu_rst_n, accu_distortion, accu_dist   accumulator control/data/sum
//   best_valid, best_ready, best_type, best_dist      result handshake
//
// Macro SAO_DECI_OFF_CAND_EN: SAO-off (type code NUM_TYPE, distortion 0) is a candidate.
module sao_deci_type_sched #(
    parameter int DIST_LEN     = 21,
    parameter int NUM_CATEGORY = 4,
    parameter int NUM_TYPE     = 5,
    parameter int TYPE_W       = 3,
    parameter int ACCU_W       = DIST_LEN + NUM_CATEGORY
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic [TYPE_W-1:0]          type_idx,
    input  logic signed [DIST_LEN-1:0] dist_in,
    input  logic                       dist_valid,
    output logic                       dist_ready,
    output logic                       accu_en,
    output logic                       accu_rst_n,
    output logic signed [DIST_LEN-1:0] accu_distortion,
    input  logic signed [ACCU_W-1:0]   accu_dist,
    output logic                       best_valid,
    input  logic                       best_ready,
    output logic [TYPE_W-1:0]          best_type,
    output logic signed [ACCU_W-1:0]   best_dist
);
    typedef enum logic [2:0] {IDLE, FLUSH, ACCU, CAPT, CLR, DONE} state_t;

    localparam int CNT_W = $clog2(NUM_CATEGORY + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_CATEGORY - 1);
    localparam logic [TYPE_W-1:0] LAST_TYPE = TYPE_W'(NUM_TYPE - 1);

    state_t           state;
    logic [CNT_W-1:0] beat;
    logic             load;

`ifdef SAO_DECI_OFF_CAND_EN
    localparam logic [TYPE_W-1:0] INIT_TYPE = TYPE_W'(NUM_TYPE);
    assign load = accu_dist < best_dist;
`else
    localparam logic [TYPE_W-1:0] INIT_TYPE = '0;
    // type 0 always seeds the best register when there is no off candidate
    assign load = (type_idx == '0) || (accu_dist < best_dist);
`endif

    assign busy            = state != IDLE;
    assign dist_ready      = state == ACCU;
    assign best_valid      = state == DONE;
    assign accu_distortion = dist_in;
    // CLR issues the accumulator's terminal enable, which clears its sum and count
    assign accu_en         = !abort && ((state == ACCU && dist_valid) || state == CLR);
    assign accu_rst_n      = !(state == FLUSH || (abort && busy));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            type_idx  <= '0;
            beat      <= '0;
            best_type <= '0;
            best_dist <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    type_idx <= '0;
                    beat     <= '0;
                    if (start) begin
                        state     <= FLUSH;
                        best_type <= INIT_TYPE;
                        best_dist <= '0;
                    end
                end
                FLUSH: state <= ACCU;
                ACCU: if (dist_valid) begin
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        state <= CAPT;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                CAPT: begin
                    if (load) begin
                        best_dist <= accu_dist;
                        best_type <= type_idx;
                    end
                    state <= CLR;
                end
                CLR: if (type_idx == LAST_TYPE) begin
                    state <= DONE;
                end else begin
                    type_idx <= type_idx + 1'b1;
                    state    <= ACCU;
                end
                DONE: if (best_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sao_deci_type_sched.sv
// tb_sao_deci_type_sched: directed bench with a behavioural one-type accumulator.
module tb_sao_deci_type_sched;
    localparam int DIST_LEN = 21;
    localparam int ACCU_W   = 25;
    localparam int TYPE_W   = 3;

    logic clk = 0, arst_n = 0, start = 0, abort = 0, dist_valid = 0, best_ready = 0;
    logic busy, dist_ready, accu_en, accu_rst_n, best_valid;
    logic [TYPE_W-1:0] type_idx, best_type;
    logic signed [DIST_LEN-1:0] dist_in = '0, accu_distortion;
    logic signed [ACCU_W-1:0] accu_dist, best_dist;

    logic signed [DIST_LEN-1:0] vals [5];
    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    sao_deci_type_sched dut (
        .clk(clk), .arst_n(arst_n), .start(start), .abort(abort), .busy(busy),
        .type_idx(type_idx), .dist_in(dist_in), .dist_valid(dist_valid),
        .dist_ready(dist_ready), .accu_en(accu_en), .accu_rst_n(accu_rst_n),
        .accu_distortion(accu_distortion), .accu_dist(accu_dist),
        .best_valid(best_valid), .best_ready(best_ready),
        .best_type(best_type), .best_dist(best_dist)
    );

    // one-type accumulator: 4 data enables build the sum, the 5th clears it
    logic signed [ACCU_W-1:0] acc_sum;
    int acc_cnt;
    assign accu_dist = acc_sum;
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n || !accu_rst_n) begin
            acc_sum <= '0;
            acc_cnt <= 0;
        end else if (accu_en) begin
            if (acc_cnt == 4) begin
                acc_sum <= '0;
                acc_cnt <= 0;
            end else begin
                acc_sum <= acc_sum + ACCU_W'(accu_distortion);
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_vals(input int a, input int b, input int c, input int d, input int e);
        vals[0] = DIST_LEN'(a); vals[1] = DIST_LEN'(b); vals[2] = DIST_LEN'(c);
        vals[3] = DIST_LEN'(d); vals[4] = DIST_LEN'(e);
    endtask

    // drive one CTU; gaps idle dist_valid cycles are inserted on every third ACCU cycle
    task automatic run_ctu(input int gaps, output int lat, output int ens);
        int n = 0, g = gaps, a = 0;
        lat = -1;
        ens = 0;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        while (n < 200 && lat < 0) begin
            @(negedge clk);
            dist_in = vals[type_idx];
            dist_valid = 1;
            if (dist_ready) begin
                if (g > 0 && a % 3 == 1) begin
                    dist_valid = 0;
                    g--;
                end
                a++;
            end
            #1 ens += int'(accu_en);
            @(posedge clk);
            n++;
            #1 if (best_valid) lat = n;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        best_ready = 1;
        @(posedge clk);
        #1 best_ready = 0;
        check(tag, longint'(busy), 0);
    endtask

    int lat, ens, exp_t, exp_d;
    bit ok, seen;

    initial begin
        set_vals(1, 1, -10, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_dist_ready", longint'(dist_ready), 0);
        check("rst_accu_en", longint'(accu_en), 0);
        check("rst_best_valid", longint'(best_valid), 0);
        check("rst_accu_rst_n", longint'(accu_rst_n), 1);
        check("rst_type_idx", longint'(type_idx), 0);
        check("rst_best_type", longint'(best_type), 0);
        check("rst_best_dist", longint'(best_dist), 0);
        @(negedge clk);
        arst_n = 1;

        // nominal, no stalls
        run_ctu(0, lat, ens);
        check("nom_latency", lat, 31);
        check("nom_accu_en", ens, 25);
        check("nom_best_type", longint'(best_type), 2);
        check("nom_best_dist", longint'(best_dist), -40);
        handshake("nom_idle");

        // all +3
        set_vals(3, 3, 3, 3, 3);
        run_ctu(0, lat, ens);
`ifdef SAO_DECI_OFF_CAND_EN
        exp_t = 5; exp_d = 0;
`else
        exp_t = 0; exp_d = 12;
`endif
        check("p3_best_type", longint'(best_type), exp_t);
        check("p3_best_dist", longint'(best_dist), exp_d);
        handshake("p3_idle");

        // tie between types 1 and 3
        set_vals(4, -2, 4, -2, 4);
        run_ctu(0, lat, ens);
        check("tie_best_type", longint'(best_type), 1);
        check("tie_best_dist", longint'(best_dist), -8);
        handshake("tie_idle");

        // 7 dist_valid gaps
        set_vals(1, 1, -10, 1, 1);
        run_ctu(7, lat, ens);
        check("gap_latency", lat, 38);
        check("gap_accu_en", ens, 25);
        check("gap_best_type", longint'(best_type), 2);
        check("gap_best_dist", longint'(best_dist), -40);
        handshake("gap_idle");

        // abort during type 2 ACCU
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            dist_in = vals[type_idx];
            dist_valid = 1;
            if (type_idx == 2 && dist_ready) seen = 1;
            else @(posedge clk);
        end
        check("abt_reached", longint'(seen), 1);
        abort = 1;
        #1;
        check("abt_rst_low", longint'(accu_rst_n), 0);
        check("abt_busy_before", longint'(busy), 1);
        @(posedge clk);
        #1 abort = 0;
        check("abt_idle", longint'(busy), 0);
        check("abt_rst_high", longint'(accu_rst_n), 1);
        ok = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (best_valid || busy) ok = 0;
        end
        check("abt_no_valid", longint'(ok), 1);
        run_ctu(0, lat, ens);
        check("abt_rerun_latency", lat, 31);
        check("abt_rerun_type", longint'(best_type), 2);
        check("abt_rerun_dist", longint'(best_dist), -40);

        // stall in DONE with start pulsed
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            best_ready = 0;
            start = (i == 3);
            @(posedge clk);
            #1 if (!best_valid || !busy || best_type != 2 || best_dist != -40) ok = 0;
        end
        start = 0;
        check("stall_stable", longint'(ok), 1);
        handshake("stall_idle");
        repeat (3) @(posedge clk);
        #1 check("stall_start_ignored", longint'(busy), 0);

        // most negative categories, no wrap
        set_vals(-1048576, -1048576, -1048576, -1048576, -1048576);
        run_ctu(0, lat, ens);
        check("min_best_type", longint'(best_type), 0);
        check("min_best_dist", longint'(best_dist), -4194304);
        handshake("min_idle");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sao_deci_type_sched.md
# sao_deci_type_sched

Sequencer for the SAO decision distortion accumulator. For each CTU it walks through `NUM_TYPE` SAO offset types and streams `NUM_CATEGORY` per-category distortions per type into the downstream one-type accumulator. It captures each per-type sum, tracks the minimum, and hands the winning type and its distortion to the SAO parameter writer. It sits between the per-category distortion calculator and the SAO decision output stage.

## Interface
- `DIST_LEN`, 21, width of one signed category distortion
- `NUM_CATEGORY`, 4, categories per type; must match the accumulator's category count
- `NUM_TYPE`, 5, candidate types per CTU (4 EO classes + BO)
- `TYPE_W`, 3, width of type index; must satisfy 2^TYPE_W > NUM_TYPE
- `ACCU_W`, DIST_LEN+NUM_CATEGORY, width of a per-type sum

Ports:
- `clk` in 1: clock
- `arst_n` in 1: reset, asynchronous, active-low
- `start` in 1: pulse; begins a CTU decision, honoured only in IDLE
- `abort` in 1: cancels the current decision from any state
- `busy` out 1: high in every state except IDLE
- `type_idx` out TYPE_W: type currently being accumulated, for the upstream
- `dist_in` in DIST_LEN signed: category distortion
- `dist_valid` in 1: `dist_in` valid
- `dist_ready` out 1: beat accepted when `dist_valid & dist_ready`
- `accu_en` out 1: accumulator enable
- `accu_rst_n` out 1: accumulator synchronous clear, active-low
- `accu_distortion` out DIST_LEN signed: accumulator data input
- `accu_dist` in ACCU_W signed: accumulator running sum
- `best_valid` out 1: result valid
- `best_ready` in 1: result consumed when `best_valid & best_ready`
- `best_type` out TYPE_W: winning type
- `best_dist` out ACCU_W signed: winning distortion

## Operation
- States: IDLE, FLUSH, ACCU, CAPT, CLR, DONE.
- IDLE:
  - `start` leads to FLUSH.
  - `type_idx` is set to 0, and the best register is initialised (see Configuration).
- FLUSH: drives `accu_rst_n` = 0 for 1 cycle, then goes to ACCU.
- ACCU:
  - `dist_ready` = 1.
  - `accu_en` = `dist_valid`.
  - `accu_distortion` = `dist_in`, passed combinationally.
  - A beat counter increments on each accepted beat. The NUM_CATEGORY-th beat leads to CAPT.
- CAPT:
  - `dist_ready` = 0 and `accu_en` = 0.
  - `accu_dist` now holds the type sum.
  - If `accu_dist` < `best_dist` (signed, strict), then `best_dist` <= `accu_dist` and `best_type` <= `type_idx`.
  - Goes to CLR.
- CLR:
  - `accu_en` = 1 and `dist_ready` = 0. This is the accumulator's terminal enable, which clears its sum and count.
  - If `type_idx` == NUM_TYPE-1, go to DONE.
  - Otherwise `type_idx`++ and go to ACCU.
- DONE:
  - `best_valid` = 1, with `best_type`/`best_dist` held stable.
  - A handshake leads to IDLE.
- Ties: the lower type index wins, because replacement is on strict less-than.
- No overflow: NUM_CATEGORY × DIST_LEN-bit sums fit in ACCU_W.
- abort:
  - From any non-IDLE state, the next state is IDLE.
  - `accu_rst_n` is driven 0 combinationally in that cycle.
  - `best_valid` falls and the result is discarded.
  - abort wins over a simultaneous `start` or `best_ready`.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `dist_ready`, `accu_en`, `best_valid` = 0.
  - `accu_rst_n` = 1.
  - `type_idx`, `best_type`, `best_dist` = 0.
- Cost per type with no stalls: NUM_CATEGORY+2 cycles.
- `best_valid` rises 1+NUM_TYPE×(NUM_CATEGORY+2) edges after the edge that samples `start`; with defaults that is 31.
- Each idle cycle on `dist_valid` in ACCU adds exactly 1 cycle.
- All outputs except `accu_en`, `accu_distortion` and `accu_rst_n` come from registers or state decodes. Those three are combinational from state plus `dist_valid`/`dist_in`/`abort`.
- Back-to-back CTUs: `start` may be asserted in the first IDLE cycle after the DONE handshake.

## Configuration
- `SAO_DECI_OFF_CAND_EN`
  - Defined: SAO-off is a candidate. The best register is initialised to `best_dist` = 0 and `best_type` = NUM_TYPE, the off code. A type wins only if its sum is < 0.
  - Undefined: no off candidate. CAPT for type 0 loads the best register unconditionally, so `best_type` is always < NUM_TYPE.

## Test plan
- Nominal, no stalls: all category distortions +1 except type 2 at −10 each. Expect `best_type` = 2 and `best_dist` = −40, with `best_valid` at edge 31 after `start`.
- All distortions +3:
  - With `SAO_DECI_OFF_CAND_EN`, expect `best_type` = 5 and `best_dist` = 0.
  - Without it, expect `best_type` = 0 and `best_dist` = 12.
- Tie: types 1 and 3 each sum to −8, all others +4. Expect `best_type` = 1.
- Random `dist_valid` gaps, 7 idle cycles in total, same data as the nominal test:
  - Same result; `best_valid` arrives at edge 38.
  - `accu_en` pulses equal 5×4 data beats + 5 CLR.
- `abort` during type 2 ACCU:
  - `accu_rst_n` low for exactly that cycle, IDLE next, `best_valid` never rises.
  - A following `start` with nominal data gives the nominal result.
- `best_ready` held low 10 cycles in DONE, with `start` pulsed: outputs stay stable and `start` is ignored. Also all categories at −2^20 give `best_dist` = −2^22 with no wrap.
